// File: rtl/reset_sequencer.sv
// Staged reset release after PLL lock; re-asserts on sw/wdt request or lock loss.
// Define RST_SEQ_CAUSE_EN to build the sticky reset-cause register.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int MIN_ASSERT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  sw_rst_req,
  input  logic                  wdt_rst_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  seq_done,
  output logic [1:0]            rst_cause
);

  localparam int DW = $clog2(STAGE_DELAY + 1);
  localparam int AW = $clog2(MIN_ASSERT + 1);
  localparam int SW = $clog2(NUM_STAGES);

  localparam logic [DW-1:0] D_LAST = DW'(STAGE_DELAY - 1);
  localparam logic [AW-1:0] A_LAST = AW'(MIN_ASSERT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    RELEASE,
    RUN,
    ASSERT
  } state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         dcnt_q, dcnt_d;
  logic [AW-1:0]         acnt_q, acnt_d;
  logic [SW-1:0]         stg_q, stg_d;
  logic [NUM_STAGES-1:0] ro_q, ro_d;
  logic                  done_q, done_d;
  logic                  abort;

  assign abort = wdt_rst_req | sw_rst_req | ~pll_locked;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    acnt_d  = acnt_q;
    stg_d   = stg_q;
    ro_d    = ro_q;
    done_d  = done_q;
    unique case (state_q)
      WAIT_LOCK: begin
        ro_d   = '1;
        done_d = 1'b0;
        if (pll_locked) begin
          state_d = RELEASE;
          dcnt_d  = '0;
          stg_d   = '0;
        end
      end
      RELEASE: begin
        if (abort) begin
          state_d = ASSERT;
        end else if (dcnt_q == D_LAST) begin
          dcnt_d      = '0;
          ro_d[stg_q] = 1'b0;
          if (stg_q == S_LAST) begin
            state_d = RUN;
            done_d  = 1'b1;
            stg_d   = '0;
          end else begin
            stg_d = stg_q + SW'(1);
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      RUN: begin
        if (abort) state_d = ASSERT;
      end
      ASSERT: begin
        if (abort) begin
          acnt_d = '0;
        end else if (acnt_q == A_LAST) begin
          state_d = WAIT_LOCK;
          acnt_d  = '0;
        end else begin
          acnt_d = acnt_q + AW'(1);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
    // Any abort re-asserts every stage at once, whatever was released.
    if (abort && state_q != WAIT_LOCK) begin
      state_d = ASSERT;
      ro_d    = '1;
      done_d  = 1'b0;
      acnt_d  = '0;
      dcnt_d  = '0;
      stg_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      dcnt_q  <= '0;
      acnt_q  <= '0;
      stg_q   <= '0;
      ro_q    <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      acnt_q  <= acnt_d;
      stg_q   <= stg_d;
      ro_q    <= ro_d;
      done_q  <= done_d;
    end
  end

  assign rst_out  = ro_q;
  assign seq_done = done_q;

`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] cause_q, cause_d;

  always_comb begin
    cause_d = cause_q;
    if (abort && state_q != WAIT_LOCK) begin
      if (!pll_locked)     cause_d = 2'd3;
      else if (wdt_rst_req) cause_d = 2'd2;
      else                 cause_d = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cause_q <= 2'd0;
    else     cause_q <= cause_d;
  end

  assign rst_cause = cause_q;
`else
  assign rst_cause = 2'b00;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expectations queued by target cycle.
// Cause checks follow RST_SEQ_CAUSE_EN.
module tb_reset_sequencer;

`ifdef RST_SEQ_CAUSE_EN
  localparam bit CAUSE_ON = 1'b1;
`else
  localparam bit CAUSE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, pll, sw, wdt;
  logic [3:0] rst_out;
  logic       seq_done;
  logic [1:0] rst_cause;

  reset_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll),
    .sw_rst_req (sw),
    .wdt_rst_req(wdt),
    .rst_out    (rst_out),
    .seq_done   (seq_done),
    .rst_cause  (rst_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] ro;
    logic       d;
    logic [1:0] ca;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  function automatic logic [1:0] ec(input logic [1:0] c);
    return CAUSE_ON ? c : 2'b00;
  endfunction

  task automatic push(input int c, input logic [3:0] ro,
                      input logic d, input logic [1:0] ca,
                      input string tag);
    exp_t e;
    e.cyc = c; e.ro = ro; e.d = d; e.ca = ca; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      n_total++;
      assert ({rst_out, seq_done, rst_cause} === {e.ro, e.d, e.ca})
        n_pass++;
      else
        $error("FAIL %s cyc=%0d got ro=%b done=%b cause=%0d exp ro=%b done=%b cause=%0d",
               e.tag, cyc, rst_out, seq_done, rst_cause, e.ro, e.d, e.ca);
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  int e0, ea, eb, ec2, ed, ef, s;

  initial begin
    rst = 1'b1; pll = 1'b1; sw = 1'b0; wdt = 1'b0;
    push(3, 4'hF, 1'b0, 2'd0, "por");
    run_to(3);

    // Clean release with lock already high.
    rst = 1'b0;
    e0 = cyc + 1;
    push(e0,      4'hF, 1'b0, 2'd0, "e0");
    push(e0 + 15, 4'hF, 1'b0, 2'd0, "pre_s0");
    push(e0 + 16, 4'hE, 1'b0, 2'd0, "s0");
    push(e0 + 32, 4'hC, 1'b0, 2'd0, "s1");
    push(e0 + 48, 4'h8, 1'b0, 2'd0, "s2");
    push(e0 + 63, 4'h8, 1'b0, 2'd0, "pre_s3");
    push(e0 + 64, 4'h0, 1'b1, 2'd0, "s3_done");
    push(e0 + 70, 4'h0, 1'b1, 2'd0, "run_hold");
    run_to(e0 + 70);

    // Software request in RUN, then full re-release.
    ea = cyc + 1;
    push(ea, 4'hF, 1'b0, ec(2'd1), "sw_run");
    sw = 1'b1; tick(); sw = 1'b0;
    push(ea + 31, 4'hF, 1'b0, ec(2'd1), "sw_assert");
    push(ea + 48, 4'hF, 1'b0, ec(2'd1), "sw_pre_s0");
    push(ea + 49, 4'hE, 1'b0, ec(2'd1), "sw_s0");
    push(ea + 96, 4'h8, 1'b0, ec(2'd1), "sw_pre_s3");
    push(ea + 97, 4'h0, 1'b1, ec(2'd1), "sw_done");
    run_to(ea + 97);

    // wdt and sw together mid-RELEASE after stage 1.
    eb = cyc + 1;
    push(eb, 4'hF, 1'b0, ec(2'd1), "sw2");
    sw = 1'b1; tick(); sw = 1'b0;
    push(eb + 65, 4'hC, 1'b0, ec(2'd1), "rel_s1");
    push(eb + 70, 4'hC, 1'b0, ec(2'd1), "rel_hold");
    run_to(eb + 70);
    ec2 = cyc + 1;
    push(ec2, 4'hF, 1'b0, ec(2'd2), "wdt_sw");
    sw = 1'b1; wdt = 1'b1; tick(); sw = 1'b0; wdt = 1'b0;
    push(ec2 + 48, 4'hF, 1'b0, ec(2'd2), "wdt_pre_s0");
    push(ec2 + 49, 4'hE, 1'b0, ec(2'd2), "wdt_s0");
    run_to(ec2 + 55);

    // rst mid-RELEASE.
    push(cyc + 1, 4'hF, 1'b0, 2'd0, "rst_mid");
    rst = 1'b1; tick(); rst = 1'b0;
    ed = cyc + 1;
    push(ed + 16, 4'hE, 1'b0, 2'd0, "rst_s0");
    push(ed + 64, 4'h0, 1'b1, 2'd0, "rst_done");
    run_to(ed + 64);

    // Lock loss in RUN, sw request 10 cycles into ASSERT.
    ef = cyc + 1;
    push(ef, 4'hF, 1'b0, ec(2'd3), "lock_loss");
    pll = 1'b0; tick(); pll = 1'b1;
    push(ef + 9, 4'hF, 1'b0, ec(2'd3), "ll_hold");
    run_to(ef + 9);
    push(ef + 10, 4'hF, 1'b0, ec(2'd1), "sw_in_assert");
    sw = 1'b1; tick(); sw = 1'b0;
    push(ef + 58, 4'hF, 1'b0, ec(2'd1), "ext_pre_s0");
    push(ef + 59, 4'hE, 1'b0, ec(2'd1), "ext_s0");
    run_to(ef + 59);

    // No lock for 100 cycles after rst.
    push(cyc + 1, 4'hF, 1'b0, 2'd0, "rst_nolock");
    rst = 1'b1; pll = 1'b0; tick(); rst = 1'b0;
    s = cyc;
    push(s + 1,   4'hF, 1'b0, 2'd0, "nolock_1");
    push(s + 50,  4'hF, 1'b0, 2'd0, "nolock_50");
    push(s + 100, 4'hF, 1'b0, 2'd0, "nolock_100");
    run_to(s + 100);
    pll = 1'b1;
    e0 = cyc + 1;
    push(e0 + 15, 4'hF, 1'b0, 2'd0, "late_pre_s0");
    push(e0 + 16, 4'hE, 1'b0, 2'd0, "late_s0");
    push(e0 + 64, 4'h0, 1'b1, 2'd0, "late_done");
    run_to(e0 + 64);

    n_total++;
    assert (q.size() === 0)
      n_pass++;
    else
      $error("FAIL sb_drain got %0d pending exp 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
